// File: rtl/lab5_rr_arbiter.sv
// Round-robin arbiter: eight requesters share one resource, grant held until release.
// Optional macro ARB_TIMEOUT_EN bounds a contended hold to MAX_HOLD cycles.
module lab5_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;

    // Rotate so the search start lands at bit 0, priority-encode, then un-rotate.
    logic [2:0]  search_start;
    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_id;
    logic        win_found;
    logic        release_now;

    assign search_start = ptr_q + 3'd1;
    assign req_dbl      = {req, req};
    assign req_rot      = req_dbl[search_start +: 8];
    assign win_found    = |req_rot;
    assign win_id       = search_start + win_off;

    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       others_waiting;
    logic       timeout_hit;

    assign others_waiting = |(req & ~gnt_q);
    assign timeout_hit    = (hold_cnt_q == HOLD_LAST) && others_waiting;
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    // A preempted owner is treated exactly like one that released.
    assign release_now = (state_q == IDLE) || !req[gnt_id_q] || timeout_hit;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        if (release_now) begin
            if (win_found) begin
                state_d     = GRANT;
                ptr_d       = win_id;
                gnt_d       = 8'd1 << win_id;
                gnt_id_d    = win_id;
                gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d  = 8'd0;
`endif
            end else begin
                state_d     = IDLE;
                gnt_d       = 8'd0;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d  = 8'd0;
`endif
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt_q != HOLD_LAST) begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd7;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: doc/lab5_rr_arbiter.md
# lab5_rr_arbiter

Round-robin arbiter sharing one 8-input priority-encoder resource among eight requesters. Each cycle it samples a request vector, selects one owner by rotating priority, and holds that grant until the owner releases. It drives a one-hot grant, the encoded owner index and a valid flag. It sits in front of the 8-to-3 encoder datapath in lab5 as its scheduler.

## Interface
- MAX_HOLD, 16: maximum cycles a grant is held while others wait. Used only with ARB_TIMEOUT_EN. Legal range 2..255.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i high = requester i wants the resource.
- gnt  output  8  one-hot grant, registered; all-zero when no owner.
- gnt_id  output  3  binary index of the current owner, registered.
- gnt_valid  output  1  high when gnt is non-zero, registered.

## Operation
- State: FSM {IDLE, GRANT}; ptr[2:0] holds the last granted index; hold_cnt[7:0] exists only with ARB_TIMEOUT_EN.
- Winner selection (combinational):
  - The search starts at index ptr+1 (mod 8) and proceeds ascending with wrap.
  - The first set bit of req wins.
  - Implemented as rotate, priority encode, un-rotate.
- IDLE:
  - If req != 0, grant the winner and go to GRANT.
  - Otherwise stay in IDLE with all outputs zero.
- GRANT, owner still requesting (req[gnt_id]=1):
  - Hold the grant unchanged.
  - Other requesters cannot preempt, except via the timeout.
- GRANT, owner released (req[gnt_id]=0):
  - If any other req bit is set, switch directly to the new winner, with no idle cycle.
  - Otherwise clear the outputs and go to IDLE.
- ptr update: on every new grant, ptr <= new gnt_id. ptr is unchanged in IDLE.
- Winner search on a switch uses the updated ptr, i.e. it starts after the releasing owner.
- Output invariants:
  - gnt == (gnt_valid ? 1<<gnt_id : 0) at all times.
  - gnt_id == 0 whenever gnt_valid == 0.
- Reset values:
  - state IDLE, gnt 8'h00, gnt_id 3'd0, gnt_valid 0.
  - ptr 3'd7, so the first search starts at index 0.
  - hold_cnt 0.
- Reset mid-grant: the grant drops on the next edge regardless of req.

## Timing
- Latency: req sampled at edge N; gnt/gnt_id/gnt_valid valid after edge N (one registered stage).
- Release: owner req low before edge M causes the next owner, or zero, to appear after edge M.
- Simultaneous release and new request in the same cycle: both are considered at the same edge, and the new request can win immediately.
- The owner deasserting and reasserting req within one cycle is seen as a release only if req is low at the sampling edge.
- A request pulse shorter than one cycle between edges is ignored.
- Steady-state fairness: with all 8 requesting and each owner holding exactly one cycle, grants rotate 0,1,...,7,0 with one new owner per cycle.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt clears on every new grant and increments each cycle in GRANT, saturating at MAX_HOLD-1.
  - When hold_cnt == MAX_HOLD-1 and another requester is waiting, the owner is preempted at that edge.
  - The preempted requester is treated as having released: grant goes to the next winner after it and ptr advances.
  - With no other requester waiting, the owner keeps the grant and hold_cnt stays saturated.
  - Maximum continuous hold while contended: MAX_HOLD cycles.
- Not defined:
  - No counter logic is present.
  - A grant is held until the owner releases, with no upper bound.
  - MAX_HOLD is ignored.

## Test plan
- Reset/idle: rst=1 for 2 cycles, then req=0 -> gnt=00, gnt_id=0, gnt_valid=0 throughout.
- Single request: req=8'h10 at edge N -> gnt=8'h10, gnt_id=4, valid=1 after N. req=0 at edge N+5 -> all outputs zero after N+5.
- Round-robin: req=8'hFF held, owner drops its bit for one cycle on each grant -> gnt_id sequence 0,1,2,...,7,0. No requester is granted twice before all others.
- Direct handoff: owner 3 (req=8'h28) drops bit 3 (req=8'h20) -> gnt=8'h20, gnt_id=5 on the very next edge, with gnt_valid never low.
- Wrap and pointer: last grant 6, then req=8'h41 and owner 6 releases -> gnt_id=0, not 6.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h03 held constantly, owner 0 -> preempted after 4 cycles in grant, gnt_id=1. Four cycles later gnt_id=0 again. With req=8'h01 alone, owner 0 holds indefinitely. Without the macro, owner 0 holds indefinitely even with req=8'h03.
